// File: rtl/multicycle_core.sv
// Multicycle processor for the 16-bit ISA: one FSM sequences fetch/decode/exec/mem/wb
// around a single shared ALU, with req/ack instruction and data memory ports.
module multicycle_core #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int RESET_PC   = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [15:0]           imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  retire,
  output logic                  halted,
  output logic                  illegal,
  output logic [ADDR_WIDTH-1:0] pc
);
  typedef enum logic [2:0] {sFetch, sDecode, sExec, sMem, sWb, sHalt} stateT;

  localparam logic [3:0] OpRtype = 4'h0, OpAddi = 4'h1, OpLw = 4'h2, OpSw = 4'h3;
  localparam logic [3:0] OpBeq = 4'h4, OpBne = 4'h5, OpJ = 4'h6, OpHalt = 4'hF;
  localparam logic [ADDR_WIDTH-1:0] ResetPc = ADDR_WIDTH'(RESET_PC);

  stateT state, nextState;
  logic [15:0] ir;
  logic [ADDR_WIDTH-1:0] pcReg;
  logic signed [DATA_WIDTH-1:0] regFile [8];
  logic signed [DATA_WIDTH-1:0] aReg, bReg, aluOut, mdr;
  logic haltedReg, illegalReg;

  logic [3:0] op;
  logic [2:0] rs, rt, rd, funct, aluFn, wbDest;
  logic signed [DATA_WIDTH-1:0] imm, rsVal, rtVal, aluB, aluRes, wbData;
  logic isBranch, legal, taken, retireC;

  function automatic logic signed [DATA_WIDTH-1:0] aluCalc(
    input logic [2:0] fn,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    case (fn)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return {{(DATA_WIDTH-1){1'b0}}, (a < b)};
      default: return '0;
    endcase
  endfunction

  assign op       = ir[15:12];
  assign rs       = ir[11:9];
  assign rt       = ir[8:6];
  assign rd       = ir[5:3];
  assign funct    = ir[2:0];
  assign imm      = {{(DATA_WIDTH-6){ir[5]}}, ir[5:0]};
  assign rsVal    = (rs == 3'd0) ? '0 : regFile[rs];
  assign rtVal    = (rt == 3'd0) ? '0 : regFile[rt];
  assign isBranch = (op == OpBeq) || (op == OpBne);

  // Branches reuse the subtractor and test its result for zero.
  assign aluFn  = (op == OpRtype) ? funct : (isBranch ? 3'b001 : 3'b000);
  assign aluB   = ((op == OpRtype) || isBranch) ? bReg : imm;
  assign aluRes = aluCalc(aluFn, aReg, aluB);
  assign taken  = ((op == OpBeq) && (aluRes == '0)) || ((op == OpBne) && (aluRes != '0));

  assign wbDest = (op == OpRtype) ? rd : rt;
  assign wbData = (op == OpLw) ? mdr : aluOut;

  always_comb begin
    case (op)
      OpRtype:                                       legal = (funct[2:1] != 2'b11);
      OpAddi, OpLw, OpSw, OpBeq, OpBne, OpJ, OpHalt: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
  end

  always_comb begin
    nextState = state;
    retireC   = 1'b0;
    case (state)
      sFetch:  if (imem_ack) nextState = sDecode;
      sDecode: begin
        if (!legal || (op == OpHalt)) begin
          nextState = sHalt;
          retireC   = legal;
        end else begin
          nextState = sExec;
        end
      end
      sExec: begin
        if (isBranch || (op == OpJ)) begin
          nextState = sFetch;
          retireC   = 1'b1;
        end else if ((op == OpLw) || (op == OpSw)) begin
          nextState = sMem;
        end else begin
          nextState = sWb;
        end
      end
      sMem: begin
        if (dmem_ack) begin
          nextState = (op == OpSw) ? sFetch : sWb;
          retireC   = (op == OpSw);
        end
      end
      sWb: begin
        nextState = sFetch;
        retireC   = 1'b1;
      end
      default: nextState = sHalt;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= sFetch;
    else          state <= nextState;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcReg      <= ResetPc;
      ir         <= '0;
      haltedReg  <= 1'b0;
      illegalReg <= 1'b0;
    end else begin
      if ((state == sFetch) && imem_ack) begin
        ir    <= imem_rdata;
        pcReg <= pcReg + ADDR_WIDTH'(1);
      end
      if (state == sDecode) begin
        if (!legal) begin
          illegalReg <= 1'b1;
          haltedReg  <= 1'b1;
        end else if (op == OpHalt) begin
          haltedReg <= 1'b1;
        end
      end
      // pc already points past the branch, so the offset is added to pc+1.
      if (state == sExec) begin
        if (taken)           pcReg <= pcReg + imm[ADDR_WIDTH-1:0];
        else if (op == OpJ)  pcReg <= ADDR_WIDTH'(ir[11:0]);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      aReg   <= '0;
      bReg   <= '0;
      aluOut <= '0;
      mdr    <= '0;
      for (int i = 0; i < 8; i++) regFile[i] <= '0;
    end else begin
      if (state == sDecode) begin
        aReg <= rsVal;
        bReg <= rtVal;
      end
      if (state == sExec) aluOut <= aluRes;
      if ((state == sMem) && dmem_ack && (op == OpLw)) mdr <= dmem_rdata;
      if ((state == sWb) && (wbDest != 3'd0)) regFile[wbDest] <= wbData;
    end
  end

  // Requests are gated by reset_n so they drop the instant reset asserts.
  assign imem_req   = (state == sFetch) && reset_n;
  assign imem_addr  = pcReg;
  assign dmem_req   = (state == sMem) && reset_n;
  assign dmem_we    = (state == sMem) && (op == OpSw);
  assign dmem_addr  = aluOut[ADDR_WIDTH-1:0];
  assign dmem_wdata = bReg;
  assign retire     = retireC;
  assign halted     = haltedReg;
  assign illegal    = illegalReg;
  assign pc         = pcReg;
endmodule
